// File: rtl/i2c_pkg.sv
// Shared types and constants for the arbitrated single-byte I2C master.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] SLAVE_ADDR = 7'b1110101;
  localparam logic [DATA_W-1:0] SLAVE_DATA = 8'b10100110;

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ACK1, WRITE, READ, ACK2, STOP
  } state_t;

  // One latched request: everything the engine needs once a grant is given.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

endpackage

// File: rtl/i2c_bit_timer.sv
// SCL phase generator: scl low for the first half of each period, strobes for drive/sample/end.
// Latency: strobes are decoded combinationally from the phase register; phase restarts at 0 when enabled.
// Backpressure: none; free-runs while en=1 and is held at phase 0 otherwise.
module i2c_bit_timer #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic scl,
  output logic half_stb,
  output logic drive_stb,
  output logic sample_stb,
  output logic bit_end
);

  localparam int PH_W = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0] PH_Q    = PH_W'(CLK_DIV / 4);
  localparam logic [PH_W-1:0] PH_H    = PH_W'(CLK_DIV / 2);
  localparam logic [PH_W-1:0] PH_3Q   = PH_W'(3 * CLK_DIV / 4);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] ph;

  // Phase counter: wraps each SCL period, parked at 0 while the bus is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             ph <= '0;
    else if (!en)           ph <= '0;
    else if (ph == PH_LAST) ph <= '0;
    else                    ph <= ph + 1'b1;
  end

  assign scl        = (ph >= PH_H);
  assign half_stb   = en && (ph == PH_H - 1'b1);
  assign drive_stb  = en && (ph == PH_Q);
  assign sample_stb = en && (ph == PH_3Q);
  assign bit_end    = en && (ph == PH_LAST);

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter feeding a one-byte I2C master (START, addr+rw, ACK, byte, ACK, STOP); I2C_RETRY_EN adds address-NACK retries.
// Latency: grant one cycle after req seen in IDLE; done pulses on IDLE entry after the STOP period.
// Backpressure: req is a level; grant is held until done, req changes meanwhile are ignored.
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int CLK_DIV   = 10,
  parameter int RETRY_MAX = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_rw,
  input  logic [ADDR_W*N_REQ-1:0] req_addr,
  input  logic [DATA_W*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    done,
  output logic                    nack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    scl,
  inout  wire                     sda
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state, state_nxt;
  txn_t               txn, txn_win;
  logic [IDX_W-1:0]   rr_ptr, win_idx, cand;
  logic [N_REQ-1:0]   win_oh;
  logic [DATA_W-1:0]  sh, rx;
  logic [2:0]         bit_cnt;
  logic               sda_oe, sda_oe_nxt, sda_in, nack_r, retry_pend;
  logic               scl_base, half_stb, drive_stb, sample_stb, bit_end;

  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .en         (busy),
    .scl        (scl_base),
    .half_stb   (half_stb),
    .drive_stb  (drive_stb),
    .sample_stb (sample_stb),
    .bit_end    (bit_end)
  );

  assign busy   = (state != IDLE);
  assign scl    = (state == IDLE || state == START) ? 1'b1 : scl_base;
  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;

  // Rotating priority: the nearest asserted req above rr_ptr wins (scan from far to near so near overwrites).
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (req[cand]) win_idx = cand;
    end
    txn_win.rw    = req_rw[win_idx];
    txn_win.addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    txn_win.wdata = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  // State and SDA driver registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sda_oe <= 1'b0;
    end else begin
      state  <= state_nxt;
      sda_oe <= sda_oe_nxt;
    end
  end

  // Next state and SDA drive: bits change at the quarter point, START/STOP edges happen while scl is high.
  always_comb begin
    state_nxt  = state;
    sda_oe_nxt = sda_oe;
    case (state)
      IDLE:  if (|req) state_nxt = START;
      START: begin
        if (half_stb) sda_oe_nxt = 1'b1;
        if (bit_end)  state_nxt  = ADDR;
      end
      ADDR, WRITE: begin
        if (drive_stb) sda_oe_nxt = ~sh[DATA_W-1];
        if (bit_end && bit_cnt == 3'd7) state_nxt = (state == ADDR) ? ACK1 : ACK2;
      end
      READ: begin
        if (drive_stb) sda_oe_nxt = 1'b0;
        if (bit_end && bit_cnt == 3'd7) state_nxt = ACK2;
      end
      ACK1: begin
        if (drive_stb) sda_oe_nxt = 1'b0;
        if (bit_end)   state_nxt  = nack_r ? STOP : (txn.rw ? READ : WRITE);
      end
      ACK2: begin
        if (drive_stb) sda_oe_nxt = 1'b0;
        if (bit_end)   state_nxt  = STOP;
      end
      STOP: begin
        if (drive_stb)  sda_oe_nxt = 1'b1;
        if (sample_stb) sda_oe_nxt = 1'b0;
        if (bit_end)    state_nxt  = retry_pend ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: grant capture, shift registers, ack sampling and the end-of-transaction report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt     <= '0;
      rr_ptr  <= IDX_W'(N_REQ - 1);
      txn     <= '0;
      sh      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      nack_r  <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          gnt    <= win_oh;
          rr_ptr <= win_idx;
          txn    <= txn_win;
          nack_r <= 1'b0;
        end
        START: if (bit_end) begin
          sh      <= {txn.addr, txn.rw};
          bit_cnt <= '0;
          nack_r  <= 1'b0;
        end
        ADDR, WRITE, READ: begin
          if (sample_stb && state == READ) rx <= {rx[DATA_W-2:0], sda_in};
          if (bit_end) begin
            sh      <= sh << 1;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ACK1: begin
          if (sample_stb) nack_r <= sda_in;
          if (bit_end) begin
            sh      <= txn.wdata;
            bit_cnt <= '0;
          end
        end
        // On reads the master sends NACK; whatever the slave does here is ignored.
        ACK2: if (sample_stb && !txn.rw) nack_r <= sda_in;
        STOP: if (bit_end && !retry_pend) begin
          done <= 1'b1;
          gnt  <= '0;
          nack <= nack_r;
          if (txn.rw && !nack_r) rdata <= rx;
        end
        default: ;
      endcase
    end
  end

`ifdef I2C_RETRY_EN
  localparam int RC_W = $clog2(RETRY_MAX + 2);
  logic [RC_W-1:0] retry_cnt;

  // An address NACK with attempts left arms a re-START after the STOP that follows it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
    end else if (state == IDLE) begin
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
    end else if (state == ACK1 && bit_end && nack_r && int'(retry_cnt) < RETRY_MAX) begin
      retry_cnt  <= retry_cnt + 1'b1;
      retry_pend <= 1'b1;
    end else if (state == STOP && bit_end) begin
      retry_pend <= 1'b0;
    end
  end
`else
  logic retry_unused;
  assign retry_pend   = 1'b0;
  assign retry_unused = (RETRY_MAX > 0);
`endif

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: behavioural I2C slave on a pulled-up SDA plus a transaction-level reference.
// Latency: checks grant, done pulse, SCL/START/STOP counts per transaction.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
`timescale 1ns/1ps
module tb_i2c_master_arbiter;
  import i2c_pkg::*;

  localparam int N    = 2;
  localparam int DIV  = 8;
  localparam int RMAX = 2;
`ifdef I2C_RETRY_EN
  localparam int ATTEMPTS = RMAX + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N-1:0]        req_rw = '0;
  logic [ADDR_W*N-1:0] req_addr = '0;
  logic [DATA_W*N-1:0] req_wdata = '0;
  logic [N-1:0]        gnt;
  logic                busy, done, nack, scl;
  logic [DATA_W-1:0]   rdata;
  wire                 sda_w;
  logic                s_pull = 1'b0;

  pullup (sda_w);
  assign sda_w = s_pull ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_arbiter #(.N_REQ(N), .CLK_DIV(DIV), .RETRY_MAX(RMAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .nack      (nack),
    .rdata     (rdata),
    .scl       (scl),
    .sda       (sda_w)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  int          s_st = 0, s_cnt = 0;
  logic [7:0]  s_sh = '0, s_rd = '0, slave_rx = '0;
  logic        s_rw = 1'b0, m_ack = 1'b0;
  logic        p_scl = 1'b1, p_sda = 1'b1;
  int          starts = 0, stops = 0, scl_rises = 0;

  always @(scl or sda_w) begin
    if (scl === 1'b1 && p_scl === 1'b1 && sda_w === 1'b0 && p_sda === 1'b1) begin
      s_st = 1; s_cnt = 0; s_pull = 1'b0; starts++;
    end else if (scl === 1'b1 && p_scl === 1'b1 && sda_w === 1'b1 && p_sda === 1'b0) begin
      s_st = 0; s_pull = 1'b0; stops++;
    end else if (scl === 1'b1 && p_scl === 1'b0) begin
      scl_rises++;
      if (s_st == 1 || s_st == 3) begin
        s_sh = {s_sh[6:0], sda_w}; s_cnt++;
      end else if (s_st == 6) begin
        m_ack = sda_w; s_st = 0;
      end
    end else if (scl === 1'b0 && p_scl === 1'b1) begin
      case (s_st)
        1: if (s_cnt == 8) begin
             if (s_sh[7:1] == SLAVE_ADDR) begin s_rw = s_sh[0]; s_pull = 1'b1; s_st = 2; end
             else s_st = 0;
           end
        2: begin
             s_cnt = 0;
             if (s_rw) begin
               s_rd = SLAVE_DATA; s_pull = ~s_rd[7]; s_rd = s_rd << 1; s_cnt = 1; s_st = 5;
             end else begin
               s_pull = 1'b0; s_st = 3;
             end
           end
        3: if (s_cnt == 8) begin slave_rx = s_sh; s_pull = 1'b1; s_st = 4; end
        4: begin s_pull = 1'b0; s_st = 0; end
        5: if (s_cnt == 8) begin s_pull = 1'b0; s_st = 6; end
           else begin s_pull = ~s_rd[7]; s_rd = s_rd << 1; s_cnt++; end
        default: ;
      endcase
    end
    p_scl = scl;
    p_sda = sda_w;
  end

  // ---------------- transaction-level reference ----------------
  int         rr = N - 1;
  logic [7:0] exp_rdata = '0;

  task automatic do_txn(input logic [N-1:0] rq, input bit hold, input int drop_delay, input string tag);
    int win, n, s0, p0, r0, idx, exp_att, exp_rise;
    logic [ADDR_W-1:0] a;
    logic rw, match, gnt_ok;
    logic [N-1:0] gexp;
    win = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (rr + k) % N;
      if (rq[idx]) win = idx;
    end
    a        = req_addr[win*ADDR_W +: ADDR_W];
    rw       = req_rw[win];
    match    = (a == SLAVE_ADDR);
    exp_att  = match ? 1 : ATTEMPTS;
    exp_rise = match ? 19 : 10 * ATTEMPTS;
    gexp     = '0;
    gexp[win] = 1'b1;
    s0 = starts; p0 = stops; r0 = scl_rises;

    @(negedge clk);
    req = rq;
    n = 0;
    while (gnt === '0 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_gnt"}, gnt, gexp);
    check({tag, "_busy"}, busy, 1);
    repeat (drop_delay) @(negedge clk);
    if (!hold) req = '0;

    n = 0; gnt_ok = 1'b1;
    while (done !== 1'b1 && n < 3000) begin
      if (gnt !== gexp) gnt_ok = 1'b0;
      @(negedge clk); n++;
    end
    if (rw && match) exp_rdata = SLAVE_DATA;
    check({tag, "_done"}, done, 1);
    check({tag, "_gnt_held"}, gnt_ok, 1);
    check({tag, "_gnt_clr"}, gnt, 0);
    check({tag, "_busy_clr"}, busy, 0);
    check({tag, "_nack"}, nack, !match);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_starts"}, starts - s0, exp_att);
    check({tag, "_stops"}, stops - p0, exp_att);
    check({tag, "_scl_rises"}, scl_rises - r0, exp_rise);
    if (match && !rw) check({tag, "_slave_rx"}, slave_rx, req_wdata[win*DATA_W +: DATA_W]);
    if (match && rw)  check({tag, "_master_nack"}, m_ack, 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    rr = win;
  endtask

  task automatic set_req(input int i, input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_rw[i] = rw;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sda_w, 1);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: write to the slave; 2: read from it; 3: unknown address
    set_req(0, 1'b0, 7'h75, 8'h3C);
    do_txn(2'b01, 1'b0, 0, "t1_write");
    set_req(1, 1'b1, 7'h75, 8'h00);
    do_txn(2'b10, 1'b0, 0, "t2_read");
    set_req(0, 1'b0, 7'h10, 8'h55);
    do_txn(2'b01, 1'b0, 0, "t3_addr_nack");

    // 6: req dropped a cycle after grant still completes
    set_req(0, 1'b0, 7'h75, 8'h81);
    do_txn(2'b01, 1'b0, 1, "t6_drop");
    set_req(1, 1'b1, 7'h75, 8'h00);
    do_txn(2'b10, 1'b0, 0, "t_read2");

    // 4: both requesting back to back -> strict rotation 01,10,01,10
    set_req(0, 1'b0, 7'h75, 8'hA1);
    set_req(1, 1'b0, 7'h75, 8'h5E);
    do_txn(2'b11, 1'b1, 0, "t4_rr0");
    do_txn(2'b11, 1'b1, 0, "t4_rr1");
    do_txn(2'b11, 1'b1, 0, "t4_rr2");
    do_txn(2'b11, 1'b0, 0, "t4_rr3");

    // 5: reset in the middle of the write data bits
    set_req(0, 1'b0, 7'h75, 8'hC3);
    @(negedge clk);
    req = 2'b01;
    n = 0;
    while (gnt === '0 && n < 50) begin @(negedge clk); n++; end
    check("t5_gnt", gnt, 2'b01);
    req = '0;
    repeat (100) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_scl", scl, 1);
    check("t5_sda", sda_w, 1);
    check("t5_gnt", gnt, 0);
    check("t5_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    rr = N - 1;
    exp_rdata = '0;
    repeat (2) @(negedge clk);
    do_txn(2'b01, 1'b0, 0, "t5_after");

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_ADDR,
                8'($urandom_range(0, 255)));
      do_txn(N'($urandom_range(1, 3)), 1'b0, int'($urandom_range(0, 2)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
